// File: rtl/cla_pkg.sv
// Shared types and constants for the carry-lookahead subtractor datapath.
// Stage-1 capture record, result flags and a reference group P/G helper.
package cla_pkg;

  localparam int GRP       = 4;
  localparam int CLA_WIDTH = 8;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] g;
    logic [CLA_WIDTH-1:0] p;
    logic                 c0;
    logic                 a_msb;
    logic                 b_msb;
  } s1_t;

  typedef struct packed {
    logic borrow;
    logic ovf;
    logic zero;
    logic neg;
  } flag_t;

  // Returns {group_generate, group_propagate} for one GRP-bit lookahead group.
  function automatic logic [1:0] grp_pg(input logic [GRP-1:0] g, input logic [GRP-1:0] p);
    logic gg;
    logic gp;
    gg = 1'b0;
    gp = 1'b1;
    for (int i = 0; i < GRP; i++) begin
      gg = g[i] | (p[i] & gg);
      gp = gp & p[i];
    end
    return {gg, gp};
  endfunction

endpackage

// File: rtl/cla_borrow_group.sv
// 4-bit lookahead block: bit carries c[3:0] from cin plus group generate/propagate.
// Combinational, zero latency; all AND-OR terms are NAND-NAND pairs.
module cla_borrow_group (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       grp_g,
  output logic       grp_p
);

  // gN/pN are prefix generate/propagate over bits N..0
  logic g1, g2, g3, p1, p2, p3;
  logic x1, y1, z1, x2, y2, z2, x3, y3, z3;
  logic xc1, yc1, xc2, yc2, xc3, yc3;

  nand_2 u_x1 (.a(p[1]), .b(g[0]), .y(x1));
  nand_2 u_y1 (.a(g[1]), .b(g[1]), .y(y1));
  nand_2 u_g1 (.a(x1),   .b(y1),   .y(g1));
  nand_2 u_z1 (.a(p[1]), .b(p[0]), .y(z1));
  nand_2 u_p1 (.a(z1),   .b(z1),   .y(p1));

  nand_2 u_x2 (.a(p[2]), .b(g1),   .y(x2));
  nand_2 u_y2 (.a(g[2]), .b(g[2]), .y(y2));
  nand_2 u_g2 (.a(x2),   .b(y2),   .y(g2));
  nand_2 u_z2 (.a(p[2]), .b(p1),   .y(z2));
  nand_2 u_p2 (.a(z2),   .b(z2),   .y(p2));

  nand_2 u_x3 (.a(p[3]), .b(g2),   .y(x3));
  nand_2 u_y3 (.a(g[3]), .b(g[3]), .y(y3));
  nand_2 u_g3 (.a(x3),   .b(y3),   .y(g3));
  nand_2 u_z3 (.a(p[3]), .b(p2),   .y(z3));
  nand_2 u_p3 (.a(z3),   .b(z3),   .y(p3));

  // Every bit carry is a single AND-OR of cin with a prefix term
  nand_2 u_xc1 (.a(p[0]), .b(cin),  .y(xc1));
  nand_2 u_yc1 (.a(g[0]), .b(g[0]), .y(yc1));
  nand_2 u_c1  (.a(xc1),  .b(yc1),  .y(c[1]));
  nand_2 u_xc2 (.a(p1),   .b(cin),  .y(xc2));
  nand_2 u_yc2 (.a(g1),   .b(g1),   .y(yc2));
  nand_2 u_c2  (.a(xc2),  .b(yc2),  .y(c[2]));
  nand_2 u_xc3 (.a(p2),   .b(cin),  .y(xc3));
  nand_2 u_yc3 (.a(g2),   .b(g2),   .y(yc3));
  nand_2 u_c3  (.a(xc3),  .b(yc3),  .y(c[3]));

  assign c[0]  = cin;
  assign grp_g = g3;
  assign grp_p = p3;

endmodule

// File: rtl/nand_2.sv
// Two-input NAND cell, the common building block of the lookahead carry cells.
// Purely combinational; no state, no flow control.
module nand_2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage CLA subtractor, diff = a - b - borrow_in; 2-cycle latency, 1/cycle throughput.
// Valid/ready both sides, no skid: in_ready drops only when both stages hold and out_ready is low.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_borrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NG = WIDTH / GRP;

  if ((WIDTH % GRP) != 0 || GRP != 4 || WIDTH != CLA_WIDTH) begin : g_bad_cfg
    $error("cla_sub_pipe: WIDTH must be a multiple of GRP (4) and equal CLA_WIDTH");
  end

  logic             rst_done;
  logic             s1_valid;
  logic             s2_valid;
  logic             adv2;
  logic             load1;
  s1_t              s1;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] diff_q;
  flag_t            flags_c;
  flag_t            flags_q;

  assign adv2     = s1_valid & (~s2_valid | out_ready);
  // rst_done keeps in_ready low while reset is held and for the release edge
  assign in_ready = rst_done & (~s1_valid | adv2);
  assign load1    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      rst_done <= 1'b1;
      s1_valid <= load1 | (s1_valid & ~adv2);
      if (load1) begin
        s1.g     <= in_a & ~in_b;
        s1.p     <= in_a ^ ~in_b;
        s1.c0    <= ~in_borrow;
        s1.a_msb <= in_a[WIDTH-1];
        s1.b_msb <= in_b[WIDTH-1];
      end
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_borrow_group u_grp (
      .g     (s1.g[k*GRP +: GRP]),
      .p     (s1.p[k*GRP +: GRP]),
      .cin   (grp_c[k]),
      .c     (carry[k*GRP +: GRP]),
      .grp_g (grp_g[k]),
      .grp_p (grp_p[k])
    );
  end

  // Inter-group carries as flat sum-of-products over group G/P and c0
  always_comb begin : p_lookahead
    logic acc;
    logic pr;
    acc      = 1'b0;
    pr       = 1'b1;
    grp_c    = '0;
    grp_c[0] = s1.c0;
    for (int k = 0; k < NG; k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        pr = 1'b1;
        for (int i = j + 1; i <= k; i++) pr = pr & grp_p[i];
        acc = acc | (grp_g[j] & pr);
      end
      pr = 1'b1;
      for (int i = 0; i <= k; i++) pr = pr & grp_p[i];
      grp_c[k+1] = acc | (s1.c0 & pr);
    end
  end

  always_comb begin
    flags_c        = '0;
    diff_c         = s1.p ^ carry;
    flags_c.borrow = ~grp_c[NG];
    flags_c.ovf    = (s1.a_msb ^ s1.b_msb) & (diff_c[WIDTH-1] ^ s1.a_msb);
    flags_c.zero   = ~|diff_c;
    flags_c.neg    = diff_c[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      diff_q   <= '0;
      flags_q  <= '0;
    end else begin
      s2_valid <= adv2 | (s2_valid & ~out_ready);
      if (adv2) begin
        diff_q  <= diff_c;
        flags_q <= flags_c;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_diff   = diff_q;
  assign out_borrow = flags_q.borrow;
  assign out_ovf    = flags_q.ovf;
  assign out_zero   = flags_q.zero;
  assign out_neg    = flags_q.neg;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed and randomized checks of cla_sub_pipe: arithmetic/flags, latency,
// stall and ordering, asynchronous reset, and a scoreboard over random traffic.
module tb_cla_sub_pipe;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic [3:0] f;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_borrow;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_ovf;
  logic         out_zero;
  logic         out_neg;

  int n_cmp;
  int n_bad;

  cla_sub_pipe #(.WIDTH(W), .GRP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_borrow  (in_borrow),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] flags_now();
    return {out_borrow, out_ovf, out_zero, out_neg};
  endfunction

  // Independent reference: integer arithmetic, {diff, borrow, ovf, zero, neg}
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int u;
    int s;
    logic [7:0] d;
    u = int'(a) - int'(b) - int'(bin);
    s = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d = 8'(u);
    return {d, (u < 0), (s > 127 || s < -128), (d == 8'h00), d[7]};
  endfunction

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic [3:0] f, output int lat);
    d   = '0;
    f   = '0;
    lat = 99;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_borrow = bin;
    out_ready = 1'b1;
    #1;
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        d   = out_diff;
        f   = flags_now();
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (out_diff !== 8'h00) begin n_bad++; $display("FAIL reset_out_diff got=%h want=00", out_diff); end
    n_cmp++; if (flags_now() !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got=%b want=0000", flags_now()); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL release_in_ready got=%b want=0", in_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid); end
  endtask

  // flags are {borrow, ovf, zero, neg}
  task automatic test_vectors();
    vec_t tbl[8];
    logic [7:0] d;
    logic [3:0] f;
    int lat;
    tbl[0] = {8'h50, 8'h30, 1'b0, 8'h20, 4'b0000};
    tbl[1] = {8'h30, 8'h50, 1'b0, 8'hE0, 4'b1001};
    tbl[2] = {8'h80, 8'h01, 1'b0, 8'h7F, 4'b0100};
    tbl[3] = {8'h7F, 8'hFF, 1'b0, 8'h80, 4'b1101};
    tbl[4] = {8'h55, 8'h55, 1'b0, 8'h00, 4'b0010};
    tbl[5] = {8'h55, 8'h55, 1'b1, 8'hFF, 4'b1001};
    tbl[6] = {8'h00, 8'hFF, 1'b1, 8'h00, 4'b1010};
    tbl[7] = {8'hFF, 8'h00, 1'b1, 8'hFE, 4'b0001};
    for (int i = 0; i < 8; i++) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].bin, d, f, lat);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL vec%0d_latency got=%0d want=2", i, lat); end
      n_cmp++; if (d !== tbl[i].d) begin n_bad++; $display("FAIL vec%0d_diff got=%h want=%h", i, d, tbl[i].d); end
      n_cmp++; if (f !== tbl[i].f) begin n_bad++; $display("FAIL vec%0d_flags got=%b want=%b", i, f, tbl[i].f); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[4];
    logic [7:0] got_d[4];
    logic [3:0] got_f[4];
    int got_at[4];
    int idx;
    int n;
    t[0] = {8'h10, 8'h01, 1'b0, 8'h0F, 4'b0000};
    t[1] = {8'h00, 8'h01, 1'b0, 8'hFF, 4'b1001};
    t[2] = {8'h80, 8'h80, 1'b1, 8'hFF, 4'b1001};
    t[3] = {8'h40, 8'hC0, 1'b0, 8'h80, 4'b1101};
    idx = 0;
    n   = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (idx < 4);
      in_a      = t[idx].a;
      in_b      = t[idx].b;
      in_borrow = t[idx].bin;
      #1;
      if (cyc >= 2) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall%0d_out_valid got=%b want=1", cyc, out_valid); end
        n_cmp++; if (out_diff !== t[0].d) begin n_bad++; $display("FAIL stall%0d_diff got=%h want=%h", cyc, out_diff, t[0].d); end
        n_cmp++; if (flags_now() !== t[0].f) begin n_bad++; $display("FAIL stall%0d_flags got=%b want=%b", cyc, flags_now(), t[0].f); end
      end
      if (in_valid && in_ready) idx++;
    end
    n_cmp++; if (idx != 2) begin n_bad++; $display("FAIL stall_accepted got=%0d want=2", idx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    for (int k = 0; k < 12 && n < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_a      = t[idx].a;
        in_b      = t[idx].b;
        in_borrow = t[idx].bin;
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        got_d[n]  = out_diff;
        got_f[n]  = flags_now();
        got_at[n] = k;
        n++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (n != 4) begin n_bad++; $display("FAIL drain_count got=%0d want=4", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got_d[i] !== t[i].d) begin n_bad++; $display("FAIL drain%0d_diff got=%h want=%h", i, got_d[i], t[i].d); end
      n_cmp++; if (got_f[i] !== t[i].f) begin n_bad++; $display("FAIL drain%0d_flags got=%b want=%b", i, got_f[i], t[i].f); end
      n_cmp++; if (got_at[i] != i) begin n_bad++; $display("FAIL drain%0d_cycle got=%0d want=%0d", i, got_at[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [3:0] f;
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_a      = 8'h21 + 8'(i);
      in_b      = 8'h03;
      in_borrow = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL prereset_out_valid got=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_diff !== 8'h00) begin n_bad++; $display("FAIL midreset_diff got=%h want=00", out_diff); end
    n_cmp++; if (flags_now() !== 4'b0000) begin n_bad++; $display("FAIL midreset_flags got=%b want=0000", flags_now()); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL after_reset_stale got=%b want=0", out_valid); end
    run_one(8'h9C, 8'h1D, 1'b0, d, f, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL after_reset_latency got=%0d want=2", lat); end
    n_cmp++; if (d !== 8'h7F) begin n_bad++; $display("FAIL after_reset_diff got=%h want=7f", d); end
    n_cmp++; if (f !== 4'b0100) begin n_bad++; $display("FAIL after_reset_flags got=%b want=0100", f); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;
    int sent;
    int recv;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 60000 && recv < N; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_borrow = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_unexpected got=%h want=none", {out_diff, flags_now()});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_diff, flags_now()} !== exp_v) begin
            n_bad++;
            $display("FAIL rand%0d got=%h want=%h", recv, {out_diff, flags_now()}, exp_v);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_borrow));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (recv != N) begin n_bad++; $display("FAIL rand_count got=%0d want=%0d", recv, N); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_borrow = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
